pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage in-order core. It watches the ID-stage instruction and the EX-stage instruction. It generates IF/ID stall, EX bubble-insert, IF/ID flush and a registered PC redirect. It covers load-use hazards, branch flushes, multi-cycle EX operations and the break/halt condition. It sits beside the IF/ID/EX valid-ready chain and gates those stages' handshakes.

Parameters:
XLEN, 32, PC/data width
RIDX_W, 5, register index width
MC_LAT, 4, cycles a multi-cycle EX op occupies before issue; legal range 2..15
CNT_W, 4, width of the multi-cycle down-counter

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
id_valid  in  1  ID holds a valid instruction
id_rs1  in  RIDX_W  ID source index 1
id_rs2  in  RIDX_W  ID source index 2
id_rs1_used  in  1  ID reads rs1
id_rs2_used  in  1  ID reads rs2
id_is_mc  in  1  ID instruction is multi-cycle (mul/div)
id_is_break  in  1  ID instruction is break
ex_valid  in  1  EX holds a valid instruction
ex_is_load  in  1  EX instruction is a load
ex_wreg_en  in  1  EX writes a register
ex_wreg_index  in  RIDX_W  EX destination index
ex_branch  in  1  EX resolved taken branch/jump
ex_dnpc  in  XLEN  EX branch target
mem_ready  in  1  MEM stage allows-in
if_stall  out  1  hold PC and IF/ID register
id_stall  out  1  hold ID/EX input, ID not issuing
ex_bubble  out  1  load a bubble (inst_valid=0) into EX
flush_if_id  out  1  kill IF and ID contents this cycle
redirect_valid  out  1  one-cycle PC redirect pulse
redirect_pc  out  XLEN  redirect target, valid with redirect_valid
halted  out  1  core halted by break
state  out  2  FSM state: 0 RUN, 1 LD_STALL, 2 MC_WAIT, 3 HALT

Behaviour:
- Reset: state=RUN, counter=0, redirect_pc=0. All 1-bit outputs are 0 during reset and in the first cycle after reset.
- flush_now = ex_valid & ex_branch.
- load_use = id_valid & ex_valid & ex_is_load & ex_wreg_en & ex_wreg_index!=0 & ((id_rs1_used & id_rs1==ex_wreg_index) | (id_rs2_used & id_rs2==ex_wreg_index)).
- Combinational outputs; priority order, highest first:
  - HALT: if_stall=id_stall=halted=1; flush and redirect=0.
  - flush_now: flush_if_id=1, ex_bubble=1, if_stall=id_stall=0.
  - ~mem_ready: if_stall=id_stall=1; no bubble; state and counter hold.
  - load_use (in RUN): if_stall=id_stall=ex_bubble=1.
  - MC_WAIT with counter!=0: if_stall=id_stall=ex_bubble=1.
  - Otherwise all 0.
- Redirect: on flush_now (not HALT), redirect_pc<=ex_dnpc and redirect_valid<=1 next cycle. Exactly one-cycle pulse; cleared otherwise. Back-to-back branches give back-to-back pulses with the latest target.
- FSM transitions (registered); flush_now has priority over all except HALT:
  - RUN:
    - flush_now -> RUN.
    - Else ~mem_ready -> RUN (hold).
    - Else load_use -> LD_STALL.
    - Else id_valid & id_is_mc -> MC_WAIT, counter<=MC_LAT-1.
    - Else id_valid & id_is_break -> HALT (break issues this cycle).
  - LD_STALL: exactly one bubble. Next cycle, with mem_ready, -> RUN; the load's result is then available on the MEM bypass. With ~mem_ready, hold.
  - MC_WAIT:
    - flush_now -> RUN, counter<=0 (multi-cycle op aborted).
    - Else if mem_ready and counter!=0: counter decrements.
    - When counter==0: no stall, op issues; -> RUN if mem_ready, else hold.
    - No re-entry into MC_WAIT on the issuing cycle. The exit cycle itself is not evaluated with RUN rules.
  - HALT: sticky until reset.
- load_use and id_is_mc on the same instruction: load_use first (LD_STALL), then RUN re-evaluates and enters MC_WAIT.
- Reset asserted mid-stall or mid-MC_WAIT: returns to RUN next edge, counter cleared, pending redirect dropped.
- Total stall for one MC op with mem_ready=1: MC_LAT-1 cycles.

Test Plan:
- Load x5 in EX, ID add reads rs2=x5 -> one cycle if_stall=id_stall=ex_bubble=1, state=1; then RUN, ID issues. Same case with rd=x0 -> no stall.
- ex_branch=1 with ex_dnpc=0x80000040 -> flush_if_id=ex_bubble=1 that cycle; next cycle redirect_valid=1, redirect_pc=0x80000040, for one cycle only.
- id_is_mc with MC_LAT=4, mem_ready=1 -> 3 stall+bubble cycles (counter 3,2,1), issue on 4th cycle, state back to 0.
- MC_WAIT with counter=2 and mem_ready dropped for 3 cycles -> counter holds at 2, stalls held, no bubble; resumes and completes after mem_ready returns.
- Branch flush arriving during MC_WAIT -> state=RUN next cycle, counter=0, redirect pulse; load_use and id_is_mc together -> LD_STALL precedes MC_WAIT.
- id_is_break issued -> state=3, halted=1 and all stalls held for 20 cycles, ex_branch ignored; reset -> all outputs 0, state=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use stall, branch flush,
// multi-cycle EX wait, break/halt, and a registered PC redirect pulse.
module pipe_hazard_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RIDX_W = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_is_mc,
  input  logic              id_is_break,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_wreg_en,
  input  logic [RIDX_W-1:0] ex_wreg_index,
  input  logic              ex_branch,
  input  logic [XLEN-1:0]   ex_dnpc,
  input  logic              mem_ready,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_bubble,
  output logic              flush_if_id,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              halted,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MC_WAIT  = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] MC_INIT = CNT_W'(MC_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rv_q, rv_d;
  logic [XLEN-1:0]   rpc_q, rpc_d;
  logic              first_q;
  logic              blank;
  logic              flush_now;
  logic              load_use;

  // The cycle right after reset is inert: no outputs and no transitions.
  assign blank     = reset | first_q;
  assign flush_now = ex_valid & ex_branch;
  assign load_use  = id_valid & ex_valid & ex_is_load & ex_wreg_en &
                     (ex_wreg_index != '0) &
                     ((id_rs1_used & (id_rs1 == ex_wreg_index)) |
                      (id_rs2_used & (id_rs2 == ex_wreg_index)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rv_d        = 1'b0;
    rpc_d       = rpc_q;
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_bubble   = 1'b0;
    flush_if_id = 1'b0;
    halted      = 1'b0;
    if (!blank) begin
      if (state_q == HALT) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        halted   = 1'b1;
      end else if (flush_now) begin
        flush_if_id = 1'b1;
        ex_bubble   = 1'b1;
        state_d     = RUN;
        cnt_d       = '0;
        rv_d        = 1'b1;
        rpc_d       = ex_dnpc;
      end else if (!mem_ready) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
      end else begin
        unique case (state_q)
          RUN: begin
            if (load_use) begin
              if_stall  = 1'b1;
              id_stall  = 1'b1;
              ex_bubble = 1'b1;
              state_d   = LD_STALL;
            end else if (id_valid && id_is_mc) begin
              state_d = MC_WAIT;
              cnt_d   = MC_INIT;
            end else if (id_valid && id_is_break) begin
              state_d = HALT;
            end
          end
          LD_STALL: state_d = RUN;
          MC_WAIT: begin
            // Counter zero is the issue cycle; leave without re-running RUN checks.
            if (cnt_q != '0) begin
              if_stall  = 1'b1;
              id_stall  = 1'b1;
              ex_bubble = 1'b1;
              cnt_d     = cnt_q - CNT_W'(1);
            end else begin
              state_d = RUN;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

  always_ff @(posedge clk) first_q <= reset;

  assign redirect_valid = rv_q & ~reset;
  assign redirect_pc    = rpc_q;
  assign state          = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level behavioural model
// checked every cycle, plus literal spot checks along the scenario.
module tb_pipe_hazard_ctrl;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned MC_LAT = 4;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_rs1_used, id_rs2_used, id_is_mc, id_is_break;
  logic [RIDX_W-1:0] id_rs1, id_rs2, ex_wreg_index;
  logic ex_valid, ex_is_load, ex_wreg_en, ex_branch, mem_ready;
  logic [XLEN-1:0] ex_dnpc;
  logic if_stall, id_stall, ex_bubble, flush_if_id, redirect_valid, halted;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0] state;

  int total = 0;
  int bad = 0;

  pipe_hazard_ctrl #(.XLEN(XLEN), .RIDX_W(RIDX_W), .MC_LAT(MC_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_is_mc(id_is_mc), .id_is_break(id_is_break),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_wreg_en(ex_wreg_en),
    .ex_wreg_index(ex_wreg_index), .ex_branch(ex_branch), .ex_dnpc(ex_dnpc),
    .mem_ready(mem_ready),
    .if_stall(if_stall), .id_stall(id_stall), .ex_bubble(ex_bubble),
    .flush_if_id(flush_if_id), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending-work view of the pipeline rather than a state register.
  bit        m_first = 1'b1;
  bit        m_halt = 1'b0;
  bit        m_ld = 1'b0;
  int        m_mc = -1;      // remaining stall cycles of the MC op, -1 = none
  bit        m_rv = 1'b0;
  logic [31:0] m_rpc = '0;

  always @(negedge clk) begin
    bit blank, flush, lu, e_if, e_id, e_bub, e_fl, e_h, nrv;
    int e_st;
    blank = reset || m_first;
    flush = ex_valid && ex_branch;
    lu = id_valid && ex_valid && ex_is_load && ex_wreg_en && ex_wreg_index != 0 &&
         ((id_rs1_used && id_rs1 == ex_wreg_index) || (id_rs2_used && id_rs2 == ex_wreg_index));
    e_st = m_halt ? 3 : (m_mc >= 0) ? 2 : m_ld ? 1 : 0;
    e_if = 0; e_id = 0; e_bub = 0; e_fl = 0; e_h = 0;
    if (!blank) begin
      if (m_halt) begin e_if = 1; e_id = 1; e_h = 1; end
      else if (flush) begin e_fl = 1; e_bub = 1; end
      else if (!mem_ready) begin e_if = 1; e_id = 1; end
      else if ((e_st == 0 && lu) || m_mc > 0) begin e_if = 1; e_id = 1; e_bub = 1; end
    end
    chk("m_if_stall", {31'd0, if_stall}, {31'd0, e_if});
    chk("m_id_stall", {31'd0, id_stall}, {31'd0, e_id});
    chk("m_ex_bubble", {31'd0, ex_bubble}, {31'd0, e_bub});
    chk("m_flush", {31'd0, flush_if_id}, {31'd0, e_fl});
    chk("m_halted", {31'd0, halted}, {31'd0, e_h});
    chk("m_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv && !reset});
    chk("m_redirect_pc", redirect_pc, m_rpc);
    chk("m_state", {30'd0, state}, e_st);
    // advance the model across the coming clock edge
    if (reset) begin
      m_first = 1; m_halt = 0; m_ld = 0; m_mc = -1; m_rv = 0; m_rpc = '0;
    end else begin
      nrv = 0;
      if (!blank && !m_halt) begin
        if (flush) begin
          nrv = 1; m_rpc = ex_dnpc; m_mc = -1; m_ld = 0;
        end else if (mem_ready) begin
          if (m_ld) m_ld = 0;
          else if (m_mc > 0) m_mc--;
          else if (m_mc == 0) m_mc = -1;
          else if (lu) m_ld = 1;
          else if (id_valid && id_is_mc) m_mc = MC_LAT - 1;
          else if (id_valid && id_is_break) m_halt = 1;
        end
      end
      m_rv = nrv;
      m_first = 0;
    end
  end

  task automatic idle();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    id_is_mc = 0; id_is_break = 0; ex_valid = 0; ex_is_load = 0; ex_wreg_en = 0;
    ex_wreg_index = '0; ex_branch = 0; ex_dnpc = '0; mem_ready = 1;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_load(input logic [4:0] rd);
    ex_valid = 1; ex_is_load = 1; ex_wreg_en = 1; ex_wreg_index = rd;
  endtask

  task automatic set_branch(input logic [31:0] tgt);
    ex_valid = 1; ex_branch = 1; ex_dnpc = tgt;
  endtask

  task automatic set_mc();
    id_valid = 1; id_is_mc = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; idle();
    cyc(); cyc(); #1;
    chk("rst_if_stall", {31'd0, if_stall}, 0);
    chk("rst_state", {30'd0, state}, 0);
    cyc(); reset = 0; set_branch(32'h1234); #1;  // first cycle after reset: inert
    chk("first_flush", {31'd0, flush_if_id}, 0);
    chk("first_bubble", {31'd0, ex_bubble}, 0);
    cyc(); idle(); #1;
    chk("first_rv", {31'd0, redirect_valid}, 0);

    // load-use on rs2
    cyc(); set_load(5'd5); id_valid = 1; id_rs2 = 5'd5; id_rs2_used = 1; #1;
    chk("lu_if_stall", {31'd0, if_stall}, 1);
    chk("lu_bubble", {31'd0, ex_bubble}, 1);
    cyc(); ex_valid = 0; ex_is_load = 0; ex_wreg_en = 0; #1;
    chk("lu_state1", {30'd0, state}, 1);
    chk("lu_release", {31'd0, id_stall}, 0);
    cyc(); idle(); #1;
    chk("lu_state0", {30'd0, state}, 0);
    // rd = x0 never stalls
    cyc(); set_load(5'd0); id_valid = 1; id_rs2 = 5'd0; id_rs2_used = 1; #1;
    chk("x0_no_stall", {31'd0, if_stall}, 0);

    // branch flush and redirect pulse
    cyc(); idle(); set_branch(32'h80000040); #1;
    chk("br_flush", {31'd0, flush_if_id}, 1);
    chk("br_bubble", {31'd0, ex_bubble}, 1);
    chk("br_no_stall", {31'd0, if_stall}, 0);
    cyc(); idle(); #1;
    chk("br_rv", {31'd0, redirect_valid}, 1);
    chk("br_rpc", redirect_pc, 32'h80000040);
    cyc(); #1;
    chk("br_rv_pulse", {31'd0, redirect_valid}, 0);
    cyc(); set_branch(32'h100); cyc(); set_branch(32'h200); cyc(); idle(); #1;
    chk("b2b_rv", {31'd0, redirect_valid}, 1);
    chk("b2b_rpc", redirect_pc, 32'h200);

    // multi-cycle op, mem_ready steady
    cyc(); set_mc(); #1;
    chk("mc_entry_state", {30'd0, state}, 0);
    chk("mc_entry_stall", {31'd0, if_stall}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("mc_wait_state", {30'd0, state}, 2);
      chk("mc_wait_bubble", {31'd0, ex_bubble}, 1);
    end
    cyc(); #1;
    chk("mc_issue_bubble", {31'd0, ex_bubble}, 0);
    chk("mc_issue_state", {30'd0, state}, 2);
    cyc(); idle(); #1;
    chk("mc_done_state", {30'd0, state}, 0);

    // multi-cycle op with mem_ready low while counter is 2
    cyc(); set_mc();
    cyc(); #1;
    chk("mcr_c3_bubble", {31'd0, ex_bubble}, 1);
    cyc(); mem_ready = 0; #1;
    chk("mcr_hold_stall", {31'd0, if_stall}, 1);
    chk("mcr_hold_bubble", {31'd0, ex_bubble}, 0);
    cyc(); cyc(); cyc(); mem_ready = 1; #1;
    chk("mcr_resume_bubble", {31'd0, ex_bubble}, 1);
    cyc(); cyc(); #1;
    chk("mcr_issue_stall", {31'd0, if_stall}, 0);
    cyc(); idle(); #1;
    chk("mcr_done_state", {30'd0, state}, 0);

    // branch flush during MC_WAIT
    cyc(); set_mc(); cyc();
    cyc(); set_branch(32'h00000300); #1;
    chk("mcf_flush", {31'd0, flush_if_id}, 1);
    chk("mcf_no_stall", {31'd0, if_stall}, 0);
    cyc(); idle(); #1;
    chk("mcf_state", {30'd0, state}, 0);
    chk("mcf_rpc", redirect_pc, 32'h300);
    chk("mcf_stall", {31'd0, if_stall}, 0);

    // load-use and mc on the same ID instruction
    cyc(); set_load(5'd7); set_mc(); id_rs1 = 5'd7; id_rs1_used = 1; #1;
    chk("lm_bubble", {31'd0, ex_bubble}, 1);
    cyc(); ex_valid = 0; ex_is_load = 0; ex_wreg_en = 0; #1;
    chk("lm_state1", {30'd0, state}, 1);
    cyc(); #1;
    chk("lm_run_state", {30'd0, state}, 0);
    cyc(); #1;
    chk("lm_mc_state", {30'd0, state}, 2);
    idle();
    cyc(); cyc(); cyc(); cyc(); #1;
    chk("lm_done_state", {30'd0, state}, 0);

    // mem_ready low outranks load-use
    cyc(); set_load(5'd9); id_valid = 1; id_rs1 = 5'd9; id_rs1_used = 1; mem_ready = 0; #1;
    chk("mrl_stall", {31'd0, if_stall}, 1);
    chk("mrl_bubble", {31'd0, ex_bubble}, 0);
    cyc(); mem_ready = 1; #1;
    chk("mrl_lu_bubble", {31'd0, ex_bubble}, 1);
    cyc(); idle(); #1;
    chk("mrl_state1", {30'd0, state}, 1);
    cyc(); #1;

    // reset in the middle of MC_WAIT, and with a redirect pending
    cyc(); set_mc(); cyc(); idle(); cyc(); reset = 1; #1;
    chk("rmc_stall", {31'd0, if_stall}, 0);
    cyc(); reset = 0; #1;
    chk("rmc_state", {30'd0, state}, 0);
    cyc(); cyc(); set_branch(32'h400);
    cyc(); idle(); reset = 1; #1;
    chk("rbr_rv", {31'd0, redirect_valid}, 0);
    cyc(); reset = 0; #1;
    chk("rbr_rv2", {31'd0, redirect_valid}, 0);
    chk("rbr_rpc", redirect_pc, 0);
    cyc();

    // break -> halt, sticky, branches ignored
    cyc(); id_valid = 1; id_is_break = 1; #1;
    chk("brk_issue_halted", {31'd0, halted}, 0);
    cyc(); idle(); #1;
    chk("brk_state", {30'd0, state}, 3);
    chk("brk_stall", {31'd0, if_stall}, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(); idle(); ex_valid = 1; ex_branch = i[0]; ex_dnpc = 32'h500 + i;
      mem_ready = i[1]; #1;
      chk("halt_halted", {31'd0, halted}, 1);
      chk("halt_flush", {31'd0, flush_if_id}, 0);
    end
    cyc(); idle(); #1;
    chk("halt_rv", {31'd0, redirect_valid}, 0);
    cyc(); reset = 1; #1;
    chk("halt_rst_halted", {31'd0, halted}, 0);
    chk("halt_rst_stall", {31'd0, id_stall}, 0);
    cyc(); reset = 0; #1;
    chk("halt_rst_state", {30'd0, state}, 0);
    cyc(); cyc();
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
